quadrilatero_wl_ctrl: RTL

Sequencer for the quadrilatero weight-load stage. It accepts weight-load commands and fetches the MESH_WIDTH data slices of one weight tile from the matrix register file over a request/grant/rvalid port. It drives the load stage's `ff_counter`, `weight_rdata_valid`, `clear` and `pump` controls. It also tracks how many loaded weight buffers are waiting and hands them to the systolic array on request.

---
 rtl/quadrilatero_wl_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/quadrilatero_wl_ctrl.sv
// Weight-load sequencer: fetches one MESH_WIDTH-slice tile per command.
// Define QUADRILATERO_WL_CTRL_PREFETCH_EN to allow a second buffered tile.
module quadrilatero_wl_ctrl #(
  parameter int MESH_WIDTH = 4,
  parameter int N_REGS     = 8,
  localparam int RW = $clog2(N_REGS),
  localparam int SW = $clog2(MESH_WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [RW-1:0] cmd_reg_i,
  output logic          rf_req_o,
  input  logic          rf_gnt_i,
  output logic [RW-1:0] rf_reg_o,
  output logic [SW-1:0] rf_slice_o,
  input  logic          rf_rvalid_i,
  output logic [SW-1:0] ff_counter_o,
  output logic          weight_rdata_valid_o,
  output logic          clear_o,
  output logic          pump_o,
  input  logic          array_req_i,
  output logic          array_gnt_o,
  output logic [1:0]    full_cnt_o,
  output logic          busy_o
);

`ifdef QUADRILATERO_WL_CTRL_PREFETCH_EN
  localparam logic [1:0] MAXBUF = 2'd2;
`else
  localparam logic [1:0] MAXBUF = 2'd1;
`endif
  localparam int OW = $clog2(MESH_WIDTH + 1);
  localparam logic [SW-1:0] LAST = SW'(MESH_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] issue_cnt_q, issue_cnt_d;
  logic [SW-1:0] resp_cnt_q, resp_cnt_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [1:0]    full_q, full_d;
  logic [RW-1:0] reg_q, reg_d;
  logic [OW:0]   owed;
  logic          active, accept, gnt;
  logic          rsp_fwd, rsp_disc, last_rsp, pump;

  assign active = (state_q == ISSUE) || (state_q == DRAIN);
  assign cmd_ready_o = (state_q == IDLE) && !flush_i
                    && (discard_q == '0) && (full_q < MAXBUF);
  assign accept = cmd_valid_i && cmd_ready_o;
  assign rf_req_o = (state_q == ISSUE) && !flush_i;
  assign gnt = rf_req_o && rf_gnt_i;
  // responses with nothing outstanding are protocol errors and dropped
  assign rsp_fwd = rf_rvalid_i && !flush_i && active
                && (discard_q == '0) && (outst_q != '0);
  assign rsp_disc = rf_rvalid_i && (discard_q != '0);
  assign last_rsp = rsp_fwd && (resp_cnt_q == LAST);
  assign pump = array_req_i && (full_q != 2'd0) && !flush_i;
  assign owed = {1'b0, outst_q} + {1'b0, discard_q};

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    reg_d       = reg_q;
    outst_d     = outst_q + OW'(gnt) - OW'(rsp_fwd);
    discard_d   = discard_q - OW'(rsp_disc);
    full_d      = full_q + 2'(last_rsp) - 2'(pump);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          reg_d       = cmd_reg_i;
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
        end
      end
      ISSUE: begin
        if (gnt) begin
          issue_cnt_d = issue_cnt_q + SW'(1);
          if (issue_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: state_d = state_q;
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rsp_fwd) begin
      resp_cnt_d = resp_cnt_q + SW'(1);
      if (last_rsp) state_d = IDLE;
    end
    // in-flight reads of the aborted tile are owed back as discards
    if (flush_i) begin
      state_d   = CLEAR;
      full_d    = '0;
      outst_d   = '0;
      discard_d = OW'(owed - (OW + 1)'(rf_rvalid_i && (owed != '0)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      full_q      <= '0;
      reg_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      full_q      <= full_d;
      reg_q       <= reg_d;
    end
  end

  assign rf_reg_o             = reg_q;
  assign rf_slice_o           = issue_cnt_q;
  assign ff_counter_o         = resp_cnt_q;
  assign weight_rdata_valid_o = rsp_fwd;
  assign clear_o              = (state_q == CLEAR);
  assign pump_o               = pump;
  assign array_gnt_o          = pump;
  assign full_cnt_o           = full_q;
  assign busy_o               = (state_q != IDLE) || (owed != '0);

endmodule
